// File: rtl/spi_dac_frame_rx_pkg.sv
// Frame layout and FSM encodings shared between the DAC frame receiver and the SPI DAC driver.
package spi_dac_frame_rx_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned CODE_W  = 12;

   localparam int unsigned BIT_CHAN_B = 15;
   localparam int unsigned BIT_BUF    = 14;
   localparam int unsigned BIT_GA_N   = 13;
   localparam int unsigned BIT_SHDN_N = 12;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } rx_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer chain for one asynchronous SPI pin, with level and single-cycle edge outputs.
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] chain_q;
   logic                   dly_q;
   logic [WARM_W-1:0]      warm_q;
   logic                   armed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_q <= {SYNC_STAGES{RESET_VAL}};
         dly_q   <= RESET_VAL;
         warm_q  <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], din};
         dly_q   <= chain_q[SYNC_STAGES-1];
         if (warm_q != WARM_DONE) begin
            warm_q <= warm_q + WARM_W'(1);
         end
      end
   end

   // Edges are held off until the chain has flushed its reset value, so a pin that is
   // already low when reset releases is not mistaken for a fresh edge.
   assign armed = (warm_q == WARM_DONE);
   assign level = chain_q[SYNC_STAGES-1];
   assign rise  = armed & chain_q[SYNC_STAGES-1] & ~dly_q;
   assign fall  = armed & ~chain_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_dac_frame_rx.sv
// SPI mode-0 slave that decodes 16-bit DAC command frames; the SPI pins are oversampled in the
// system clock domain, sck is never used as a clock.
module spi_dac_frame_rx
   import spi_dac_frame_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sck,
   input  logic              mosi,
   output logic              frame_valid,
   output logic              frame_err,
   output logic              chan_b,
   output logic              buf_en,
   output logic              gain_1x,
   output logic              active,
   output logic [CODE_W-1:0] code_a,
   output logic [CODE_W-1:0] code_b,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

   logic cs_lvl, cs_rise, cs_fall;
   logic sck_lvl, sck_rise, sck_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_edges;

   rx_state_e          state_q;
   logic [FRAME_W-1:0] shift_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               start_pend_q;

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (1'b1)
   ) u_sync_cs (
      .clk  (clk),
      .rst  (rst),
      .din  (cs_n),
      .level(cs_lvl),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (1'b0)
   ) u_sync_sck (
      .clk  (clk),
      .rst  (rst),
      .din  (sck),
      .level(sck_lvl),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (1'b0)
   ) u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .din  (mosi),
      .level(mosi_lvl),
      .rise (mosi_rise),
      .fall (mosi_fall)
   );

   assign unused_edges = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall};
   assign busy         = ~cs_lvl;

   // The DONE state is the cycle frame_valid/frame_err is high; the outputs are loaded on the
   // edge that enters it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         cnt_q        <= '0;
         start_pend_q <= 1'b0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         chan_b       <= 1'b0;
         buf_en       <= 1'b0;
         gain_1x      <= 1'b1;
         active       <= 1'b0;
         code_a       <= '0;
         code_b       <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cs_fall || start_pend_q) begin
                  state_q      <= StShift;
                  shift_q      <= '0;
                  cnt_q        <= '0;
                  start_pend_q <= 1'b0;
               end
            end
            StShift: begin
               if (cs_rise) begin
                  state_q <= StDone;
                  if (cnt_q == CNT_FULL) begin
                     frame_valid <= 1'b1;
                     chan_b      <= shift_q[BIT_CHAN_B];
                     buf_en      <= shift_q[BIT_BUF];
                     gain_1x     <= shift_q[BIT_GA_N];
                     active      <= shift_q[BIT_SHDN_N];
                     if (shift_q[BIT_CHAN_B]) begin
                        code_b <= shift_q[CODE_W-1:0];
                     end else begin
                        code_a <= shift_q[CODE_W-1:0];
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (sck_rise) begin
                  shift_q <= {shift_q[FRAME_W-2:0], mosi_lvl};
                  if (cnt_q != CNT_SAT) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               // A new frame may already start here; remember it for IDLE.
               if (cs_fall) begin
                  start_pend_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dac_frame_rx.sv
// Directed bench for spi_dac_frame_rx: an SPI master drives frames, a scoreboard predicts each pulse.
module tb_spi_dac_frame_rx;

   typedef struct packed {
      logic        err;
      logic        chan_b;
      logic        buf_en;
      logic        gain_1x;
      logic        active;
      logic [11:0] code_a;
      logic [11:0] code_b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cs_n = 1'b1;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        frame_valid, frame_err, chan_b, buf_en, gain_1x, active, busy;
   logic [11:0] code_a, code_b;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int pulse_cyc = -1;
   int n_valid = 0;
   int n_err = 0;
   int nv0, ne0;
   logic busy_p1 = 1'b0, busy_p2 = 1'b0;
   logic busy_at_m1 = 1'b1, busy_at_m2 = 1'b0;

   logic        m_chan_b = 1'b0, m_buf = 1'b0, m_gain = 1'b1, m_act = 1'b0;
   logic [11:0] m_a = '0, m_b = '0;
   exp_t        sb[$];

   spi_dac_frame_rx #(
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cs_n       (cs_n),
      .sck        (sck),
      .mosi       (mosi),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .chan_b     (chan_b),
      .buf_en     (buf_en),
      .gain_1x    (gain_1x),
      .active     (active),
      .code_a     (code_a),
      .code_b     (code_b),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_hc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_expect(input logic [31:0] data, input int nbits);
      exp_t e;
      if (nbits == 16) begin
         m_chan_b = data[15];
         m_buf    = data[14];
         m_gain   = data[13];
         m_act    = data[12];
         if (data[15]) m_b = data[11:0];
         else          m_a = data[11:0];
      end
      e = '{err: (nbits != 16), chan_b: m_chan_b, buf_en: m_buf, gain_1x: m_gain,
            active: m_act, code_a: m_a, code_b: m_b};
      sb.push_back(e);
   endtask

   task automatic send_bit(input logic b, input int half);
      mosi = b;
      wait_hc(half);
      sck = 1'b1;
      wait_hc(half);
      sck = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] data, input int nbits, input int half);
      push_expect(data, nbits);
      cs_n = 1'b0;
      wait_hc(half);
      for (int i = nbits - 1; i >= 0; i--) send_bit(data[i], half);
      wait_hc(half);
      cs_n     = 1'b1;
      rise_cyc = cyc;
      wait_hc(half);
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_code_a"}, code_a, m_a);
      chk({tag, "_code_b"}, code_b, m_b);
      chk({tag, "_chan_b"}, chan_b, m_chan_b);
      chk({tag, "_buf_en"}, buf_en, m_buf);
      chk({tag, "_gain_1x"}, gain_1x, m_gain);
      chk({tag, "_active"}, active, m_act);
   endtask

   // Monitor: every pulse must match the oldest predicted frame outcome.
   always @(negedge clk) begin
      exp_t e;
      if (frame_valid || frame_err) begin
         pulse_cyc  = cyc;
         busy_at_m1 = busy_p1;
         busy_at_m2 = busy_p2;
         if (frame_valid) n_valid++;
         if (frame_err) n_err++;
         chk("sb_has_entry", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pulse_valid", frame_valid, !e.err);
            chk("pulse_err", frame_err, e.err);
            chk("pulse_code_a", code_a, e.code_a);
            chk("pulse_code_b", code_b, e.code_b);
            chk("pulse_chan_b", chan_b, e.chan_b);
            chk("pulse_buf_en", buf_en, e.buf_en);
            chk("pulse_gain_1x", gain_1x, e.gain_1x);
            chk("pulse_active", active, e.active);
         end
      end
      busy_p2 = busy_p1;
      busy_p1 = busy;
   end

   initial begin
      // Reset state
      wait_hc(3);
      @(negedge clk);
      chk_outputs("reset");
      chk("reset_busy", busy, 0);
      chk("reset_valid", frame_valid, 0);
      chk("reset_err", frame_err, 0);
      wait_hc(1);
      rst = 1'b1;
      wait_hc(6);

      // 1: single frame at the production half-period
      send_frame(32'h53FF, 16, 256);
      chk("t1_valid_count", n_valid, 1);
      chk("t1_code_a", code_a, 12'h3FF);
      chk("t1_code_b", code_b, 12'h000);
      chk("t1_flags", {chan_b, buf_en, gain_1x, active}, 4'b0101);

      // 2: channel steering, other channel holds
      send_frame(32'h5123, 16, 16);
      send_frame(32'hD456, 16, 16);
      chk("t2_code_a", code_a, 12'h123);
      chk("t2_code_b", code_b, 12'h456);
      chk("t2_chan_b", chan_b, 1);

      // 3: short then long frame
      nv0 = n_valid;
      ne0 = n_err;
      send_frame(32'h2AAA, 15, 16);
      send_frame(32'h1ABCD, 17, 16);
      chk("t3_err_count", n_err - ne0, 2);
      chk("t3_valid_count", n_valid - nv0, 0);
      chk_outputs("t3");

      // 4: reset in the middle of a frame
      nv0 = n_valid;
      ne0 = n_err;
      cs_n = 1'b0;
      wait_hc(16);
      for (int i = 15; i >= 8; i--) send_bit(1'(16'h5ABC >> i), 16);
      rst = 1'b0;
      m_chan_b = 1'b0; m_buf = 1'b0; m_gain = 1'b1; m_act = 1'b0; m_a = '0; m_b = '0;
      wait_hc(2);
      @(negedge clk);
      chk_outputs("t4_in_reset");
      chk("t4_busy_in_reset", busy, 0);
      wait_hc(2);
      rst = 1'b1;
      for (int i = 7; i >= 0; i--) send_bit(1'(16'h5ABC >> i), 16);
      wait_hc(16);
      cs_n = 1'b1;
      wait_hc(16);
      chk("t4_partial_valid", n_valid - nv0, 0);
      chk("t4_partial_err", n_err - ne0, 0);
      chk_outputs("t4_after_partial");
      send_frame(32'h5ABC, 16, 16);
      chk("t4_code_a", code_a, 12'hABC);
      chk("t4_valid_count", n_valid - nv0, 1);
      chk("t4_err_count", n_err - ne0, 0);

      // 5: cs_n rise to pulse latency and busy timing
      send_frame(32'h1ABC, 16, 16);
      chk("t5_latency", pulse_cyc - rise_cyc, 3);
      chk("t5_busy_m1", busy_at_m1, 0);
      chk("t5_busy_m2", busy_at_m2, 1);

      // 6: sck activity with cs_n high is ignored
      nv0 = n_valid;
      ne0 = n_err;
      for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 8);
      wait_hc(16);
      chk("t6_idle_valid", n_valid - nv0, 0);
      chk("t6_idle_err", n_err - ne0, 0);
      send_frame(32'h4000, 16, 16);
      chk("t6_code_a", code_a, 12'h000);
      chk("t6_active", active, 0);
      chk("t6_buf_en", buf_en, 1);
      chk("t6_valid_count", n_valid - nv0, 1);

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
